// File: rtl/sensor_drain_if.sv
// ---------------------------------------------------------------------------
// sensor_drain_if
//
// Word stream from the sensor drain engine to its downstream consumer
// (DMA or FIFO).
//
// Handshake: a word transfers on a rising clk edge where m_valid and m_ready
// are both high. The master holds m_valid, m_data and m_last stable until
// that edge. m_valid never waits on m_ready. The slave may change m_ready
// at any time.
//
// Signals:
//   m_valid  master -> slave  word valid
//   m_data   master -> slave  32-bit word
//   m_last   master -> slave  final word of the frame
//   m_ready  slave  -> master consumer can accept
// ---------------------------------------------------------------------------
interface sensor_drain_if;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/sensor_drain.sv
// ---------------------------------------------------------------------------
// sensor_drain
//
// Core-side drain engine for the high-speed sensor controller.
// - Arms the controller (sctrl_en) and waits for its full interrupt.
// - Reads the DEPTH captured words over sctrl_addr/sctrl_out.
// - Streams those words out on the valid/ready interface m.
// - Pulses sctrl_clear for one cycle to re-arm the controller.
//
// Optional feature: define SENSOR_DRAIN_SUM_EN to append one extra word per
// frame. That word is the 32-bit wrapping sum of the frame's data words, and
// m_last moves from the last data word onto this sum word.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   enable           software run bit (level)
//   sctrl_interrupt  controller buffer full
//   sctrl_out[31:0]  controller read data, combinational from sctrl_addr
//   sctrl_en         controller capture enable (high in FILL)
//   sctrl_clear      one-cycle controller clear (high in CLEAR)
//   sctrl_addr       controller read address (registered read pointer)
//   m                stream master: m_valid, m_data, m_last, m_ready
//   busy             high in every state except IDLE
//   frame_cnt[15:0]  frames completed, wraps at 16 bits
//   dbg_state[2:0]   current FSM state (IDLE=0 FILL=1 DRAIN=2 CLEAR=3 SUM=4)
// ---------------------------------------------------------------------------
module sensor_drain #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sctrl_interrupt,
  input  logic [31:0]       sctrl_out,
  output logic              sctrl_en,
  output logic              sctrl_clear,
  output logic [ADDR_W-1:0] sctrl_addr,
  sensor_drain_if.master    m,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    CLEAR = 3'd3
`ifdef SENSOR_DRAIN_SUM_EN
    , SUM = 3'd4
`endif
  } state_t;

  // The pointer carries one extra bit so that the value DEPTH means
  // "every word has been read" and cannot be confused with address 0.
  localparam logic [ADDR_W:0] PTR_END   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR = PTR_END - (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q;
  logic              valid_q;
  logic [31:0]       data_q;
  logic              last_q;
  logic [15:0]       frame_q;

  logic              words_left;
  logic              accept;
  logic              load;
  logic              drain_start;

  assign words_left  = (ptr_q < PTR_END);
  assign accept      = valid_q & m.m_ready;
  // Refill the output register when it is empty or emptying this cycle.
  assign load        = (state_q == DRAIN) && (!valid_q || m.m_ready) && words_left;
  assign drain_start = (state_q == FILL) && sctrl_interrupt;

`ifdef SENSOR_DRAIN_SUM_EN
  logic [31:0] sum_q;
  logic        sum_load;

  // The last data word leaves the register, and the sum is complete, so the
  // sum word takes its place on the same edge.
  assign sum_load = (state_q == DRAIN) && accept && !words_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (drain_start) begin
      sum_q <= '0;
    end else if (load) begin
      sum_q <= sum_q + sctrl_out;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FILL;
      end
      FILL: begin
        if (sctrl_interrupt) state_d = DRAIN;
        else if (!enable)    state_d = IDLE;
      end
      DRAIN: begin
`ifdef SENSOR_DRAIN_SUM_EN
        if (sum_load) state_d = SUM;
`else
        if (accept && last_q) state_d = CLEAR;
`endif
      end
`ifdef SENSOR_DRAIN_SUM_EN
      SUM: begin
        if (accept) state_d = CLEAR;
      end
`endif
      CLEAR: begin
        state_d = enable ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pointer, output register, and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      if (drain_start || state_q == CLEAR) begin
        ptr_q <= '0;
      end else if (load) begin
        ptr_q <= ptr_q + (ADDR_W+1)'(1);
      end

      if (load) begin
        data_q  <= sctrl_out;
        valid_q <= 1'b1;
`ifdef SENSOR_DRAIN_SUM_EN
        last_q  <= 1'b0;
`else
        last_q  <= (ptr_q == LAST_ADDR);
`endif
`ifdef SENSOR_DRAIN_SUM_EN
      end else if (sum_load) begin
        data_q  <= sum_q;
        last_q  <= 1'b1;
`endif
      end else if (accept) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      if (state_q == CLEAR) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign sctrl_en    = (state_q == FILL);
  assign sctrl_clear = (state_q == CLEAR);
  assign sctrl_addr  = ptr_q[ADDR_W-1:0];
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_q;
  assign dbg_state   = state_q;

  assign m.m_valid   = valid_q;
  assign m.m_data    = data_q;
  assign m.m_last    = last_q;

endmodule

// File: tb/tb_sensor_drain.sv
// ---------------------------------------------------------------------------
// tb_sensor_drain
//
// Directed bench for sensor_drain. A small controller model holds a DEPTH-word
// buffer and raises its full flag after DEPTH enabled capture cycles.
// sctrl_clear clears that flag. Expected stream words go into exp_q.
// ---------------------------------------------------------------------------
module tb_sensor_drain;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int LIMIT  = 600;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              enable;
  logic              sctrl_interrupt;
  logic [31:0]       sctrl_out;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [2:0]        dbg_state;

  sensor_drain_if sd_if();

  sensor_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .m               (sd_if),
    .busy            (busy),
    .frame_cnt       (frame_cnt),
    .dbg_state       (dbg_state)
  );

  // controller model
  logic [31:0] mem [DEPTH];
  int          fill_cnt = 0;
  logic        full = 1'b0;
  int          clear_seen = 0;

  assign sctrl_out       = mem[sctrl_addr];
  assign sctrl_interrupt = full;

  always @(posedge clk) begin
    if (rst || sctrl_clear) begin
      fill_cnt <= 0;
      full     <= 1'b0;
    end else if (sctrl_en && !full) begin
      fill_cnt <= fill_cnt + 1;
      if (fill_cnt == DEPTH - 1) full <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (sctrl_clear) clear_seen <= clear_seen + 1;
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one frame from FILL. ready_mode 0 holds m_ready high; 1 toggles it.
  // enable drops at the drop_after-th accepted beat. The task returns early
  // after rst_after beats (0 = never).
  task automatic run_frame(input int ready_mode, input int drop_after, input int rst_after);
    int          beats;
    int          cyc;
    bit          stop;
    logic        stalled;
    logic [31:0] held;
    logic [31:0] sum;
    logic [31:0] w;
    beats = 0; cyc = 0; stop = 0; stalled = 0; held = '0; sum = '0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + mem[i];
    end
`ifdef SENSOR_DRAIN_SUM_EN
    exp_q.push_back(sum);
`endif
    while (exp_q.size() != 0 && cyc < LIMIT && !stop) begin
      sd_if.m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (stalled) begin
        check("stall_valid", 32'(sd_if.m_valid), 32'd1);
        check("stall_data", sd_if.m_data, held);
      end
      stalled = sd_if.m_valid && !sd_if.m_ready;
      held    = sd_if.m_data;
      if (sd_if.m_valid && sd_if.m_ready) begin
        w = exp_q.pop_front();
        check("data", sd_if.m_data, w);
        check("last", 32'(sd_if.m_last), 32'(exp_q.size() == 0));
        beats++;
        if (beats == drop_after) enable = 1'b0;
      end
      step(1);
      cyc++;
      if (rst_after != 0 && beats == rst_after) stop = 1;
    end
    sd_if.m_ready = 1'b1;
    if (!stop) check("frame_done_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Call in the CLEAR cycle that follows the final accept.
  task automatic check_clear(input int n, input int clears, input bit to_fill);
    check("clear_pulse", 32'(sctrl_clear), 32'd1);
    check("clear_state", 32'(dbg_state), 32'd3);
    check("clear_valid", 32'(sd_if.m_valid), 32'd0);
    check("clear_cnt_pre", 32'(frame_cnt), 32'(n - 1));
    step(1);
    check("clear_done", 32'(sctrl_clear), 32'd0);
    check("frame_cnt", 32'(frame_cnt), 32'(n));
    check("clears_seen", 32'(clear_seen), 32'(clears));
    if (to_fill) begin
      check("refill_en", 32'(sctrl_en), 32'd1);
      check("refill_state", 32'(dbg_state), 32'd1);
    end else begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_en", 32'(sctrl_en), 32'd0);
      check("idle_state", 32'(dbg_state), 32'd0);
      check("idle_addr", 32'(sctrl_addr), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en"}, 32'(sctrl_en), 32'd0);
    check({tag, "_clear"}, 32'(sctrl_clear), 32'd0);
    check({tag, "_addr"}, 32'(sctrl_addr), 32'd0);
    check({tag, "_valid"}, 32'(sd_if.m_valid), 32'd0);
    check({tag, "_data"}, sd_if.m_data, 32'd0);
    check({tag, "_last"}, 32'(sd_if.m_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    sd_if.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
    step(3);
    check_reset_values("reset");

    // Basic frame: IDLE -> FILL one cycle after enable, then 64 words.
    rst = 1'b0;
    enable = 1'b1;
    step(1);
    check("fill_en", 32'(sctrl_en), 32'd1);
    check("fill_busy", 32'(busy), 32'd1);
    run_frame(0, 0, 0);
    check_clear(1, 1, 1'b1);

    // Backpressure: m_ready alternates throughout the frame.
    run_frame(1, 0, 0);
    check_clear(2, 2, 1'b1);

    // enable drops after word 10 (the 11th beat); the frame still completes.
    run_frame(0, 11, 0);
    check_clear(3, 3, 1'b0);

    // enable drops in FILL before the interrupt.
    enable = 1'b1;
    step(1);
    check("rearm_en", 32'(sctrl_en), 32'd1);
    step(4);
    enable = 1'b0;
    step(1);
    check("fill_abort_busy", 32'(busy), 32'd0);
    check("fill_abort_en", 32'(sctrl_en), 32'd0);
    check("fill_abort_state", 32'(dbg_state), 32'd0);
    step(3);
    check("fill_abort_no_clear", 32'(clear_seen), 32'd3);
    enable = 1'b1;
    run_frame(0, 0, 0);
    check_clear(4, 4, 1'b1);

    // Reset during DRAIN after word 30.
    run_frame(0, 0, 30);
    check("pre_reset_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    step(1);
    check_reset_values("midreset");
    rst = 1'b0;
    enable = 1'b0;
    step(2);
    check("midreset_no_clear", 32'(clear_seen), 32'd4);
    check("midreset_idle", 32'(busy), 32'd0);

`ifdef SENSOR_DRAIN_SUM_EN
    // Sum of 64 words of 0x0400_0000 wraps to zero.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0400_0000;
    enable = 1'b1;
    run_frame(0, 0, 0);
    check_clear(1, 5, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sensor_drain.md
# sensor_drain

Core-side drain engine for the high-speed sensor controller. It arms the controller, waits for the full interrupt, and reads all 64 captured words out over `sctrl_addr`/`sctrl_out`. It presents those words as a valid/ready stream, then pulses `sctrl_clear` to re-arm for the next frame. It sits between the sensor controller's core port and a downstream consumer (DMA or FIFO), so the CPU no longer polls the buffer.

## Interface
Parameters:
- `DEPTH`, 64: words per frame; must equal the controller buffer depth.
- `ADDR_W`, 6: address width, log2(`DEPTH`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  software run bit; level-sensitive
- `sctrl_interrupt`  in  1  controller full flag
- `sctrl_out`  in  32  controller read data; combinational from `sctrl_addr`
- `sctrl_en`  out  1  controller capture enable
- `sctrl_clear`  out  1  controller clear pulse
- `sctrl_addr`  out  ADDR_W  controller read address
- `m_valid`  out  1  stream word valid
- `m_data`  out  32  stream word
- `m_last`  out  1  final word of frame
- `m_ready`  in  1  downstream accept
- `busy`  out  1  high in any state other than IDLE
- `frame_cnt`  out  16  frames completed; wraps at 0xFFFF -> 0

## Operation
- FSM states: IDLE, FILL, DRAIN, CLEAR; SUM is added only under the macro.
- IDLE: all controller outputs low. `enable`=1 -> FILL.
- FILL: `sctrl_en`=1.
  - `sctrl_interrupt`=1 -> DRAIN, with the read pointer set to 0.
  - `enable`=0 while `sctrl_interrupt`=0 -> IDLE. Partial frame data stays in the controller and is not cleared.
- DRAIN: `sctrl_en`=0 and `sctrl_addr`=read pointer.
  - The output register loads when `m_valid`=0 or (`m_valid` & `m_ready`) and words remain. On load: `m_data` <= `sctrl_out`, `m_valid` <= 1, pointer++.
  - `m_last`=1 on the word read from address `DEPTH`-1.
  - When the last word is accepted (`m_valid` & `m_ready` & `m_last`): `m_valid` <= 0 and the FSM goes to CLEAR.
- CLEAR: `sctrl_clear`=1 for exactly one cycle and `frame_cnt`++. Next state is FILL if `enable`=1, otherwise IDLE.
- `enable` falling during DRAIN or CLEAR has no effect until the frame completes. A frame is never truncated.
- `m_data` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- The read pointer is `ADDR_W`+1 bits internally so that "all words read" is detectable without wrap ambiguity. `sctrl_addr` is its low `ADDR_W` bits.

## Timing
- Reset values: `sctrl_en`=0, `sctrl_clear`=0, `sctrl_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `frame_cnt`=0. State is IDLE.
- `sctrl_en`, `sctrl_clear` and `busy` decode from the registered state (Moore). `sctrl_addr` is the registered pointer.
- IDLE -> FILL one cycle after `enable` rises; `sctrl_en` is high in that next cycle.
- Interrupt to first `m_valid`: 2 cycles. The DRAIN entry edge is followed by the first load edge.
- With `m_ready` held at 1, one word is accepted per cycle. A frame takes `DEPTH` cycles plus 1 for CLEAR.
- The `sctrl_clear` cycle clears the controller counter and full flag on that edge, so FILL never sees a stale interrupt.
- Reset mid-frame: immediate return to reset values, no clear pulse issued. The controller shares `rst` and also resets.

## Configuration
- `SENSOR_DRAIN_SUM_EN` defined:
  - A 32-bit wrapping sum of the frame's `DEPTH` data words is accumulated on each load.
  - The word from address `DEPTH`-1 has `m_last`=0.
  - SUM state then emits one extra word, `m_data`=sum with `m_last`=1. Its acceptance leads to CLEAR.
  - The sum resets to 0 on DRAIN entry.
- `SENSOR_DRAIN_SUM_EN` undefined: no SUM state and no accumulator. The frame is exactly `DEPTH` words.

## Test plan
- Basic frame: controller preloaded with words i+0x100 (i=0..63), `enable`=1, `m_ready`=1 -> 64 beats carrying 0x100..0x13F in order. `m_last` is high only on 0x13F. One `sctrl_clear` pulse, `frame_cnt`=1, FSM returns to FILL.
- Backpressure: `m_ready` toggles 1/0 every cycle during DRAIN -> no word lost or duplicated, and `m_data` is stable while stalled. The 64 words still arrive in order.
- Enable dropped mid-DRAIN after word 10 -> remaining 53 words still delivered, CLEAR pulse issued, then IDLE with `busy`=0 and `sctrl_en`=0.
- Enable dropped in FILL before interrupt -> IDLE next cycle and no `sctrl_clear`. Re-enable -> FILL resumes and the frame completes once the controller fills.
- Reset asserted during DRAIN at word 30 -> next cycle all outputs at reset values and `frame_cnt`=0. No `sctrl_clear` is seen.
- `SENSOR_DRAIN_SUM_EN` build, words all 0x0400_0000 -> 65th beat carries 0x0000_0000 (the sum wraps) with `m_last`=1. Word 64 has `m_last`=0.
